// File: rtl/condicionador_botoes.sv
// Synchronises and debounces twelve note keys and two arrow keys.
// Produces a note code, press pulses and a multi-key flag.
module condicionador_botoes #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] botoes,
  input  logic        right_arrow,
  input  logic        left_arrow,
  output logic [3:0]  botoes_encoded,
  output logic        right_arrow_pressed,
  output logic        left_arrow_pressed,
  output logic        nota_pulso,
  output logic        multiplos,
  output logic [11:0] db_botoes_estaveis
);

  localparam int D_RAW = CLOCK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int D     = (D_RAW < 1) ? 1 : D_RAW;
  localparam int CW    = $clog2(D + 1);
  localparam logic [CW-1:0] D_LAST = CW'(D - 1);

  typedef enum logic {OCIOSO, ATIVO} estado_t;

  logic [13:0]   raw;
  logic [13:0]   sync1;
  logic [13:0]   sync2;
  logic [13:0]   stable;
  logic [CW-1:0] cnt [14];

  assign raw = {left_arrow, right_arrow, botoes};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < 14; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 14; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == D_LAST) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [11:0] notas;
  logic [15:0] lat_vec;
  logic [3:0]  lat_idx;
  logic [3:0]  low_code;
  logic [3:0]  pop;
  logic        any_nota;
  logic        held;
  estado_t     state, state_n;
  logic [3:0]  code_n;
  logic        pulse_n;

  assign notas    = stable[11:0];
  assign any_nota = |notas;
  assign lat_vec  = {4'b0000, notas};
  assign lat_idx  = botoes_encoded - 4'd1;
  assign held     = lat_vec[lat_idx];

  always_comb begin
    low_code = 4'd0;
    pop      = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (notas[i]) low_code = 4'(i + 1);
    end
    for (int i = 0; i < 12; i++) begin
      pop = pop + 4'(notas[i]);
    end
  end

  always_comb begin
    state_n = state;
    code_n  = botoes_encoded;
    pulse_n = 1'b0;
    unique case (state)
      OCIOSO: begin
        code_n = 4'd0;
        if (any_nota) begin
          code_n  = low_code;
          pulse_n = 1'b1;
          state_n = ATIVO;
        end
      end
      ATIVO: begin
        if (!held) begin
          if (any_nota) begin
            code_n  = low_code;
            pulse_n = 1'b1;
          end else begin
            code_n  = 4'd0;
            state_n = OCIOSO;
          end
        end
      end
      default: begin
        code_n  = 4'd0;
        state_n = OCIOSO;
      end
    endcase
  end

  logic prev_r;
  logic prev_l;
  logic rise_r;
  logic rise_l;

  assign rise_r = stable[12] & ~prev_r;
  assign rise_l = stable[13] & ~prev_l;

  // Simultaneous rises cancel each other out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= OCIOSO;
      botoes_encoded      <= 4'd0;
      nota_pulso          <= 1'b0;
      multiplos           <= 1'b0;
      prev_r              <= 1'b0;
      prev_l              <= 1'b0;
      right_arrow_pressed <= 1'b0;
      left_arrow_pressed  <= 1'b0;
    end else begin
      state               <= state_n;
      botoes_encoded      <= code_n;
      nota_pulso          <= pulse_n;
      multiplos           <= (pop > 4'd1);
      prev_r              <= stable[12];
      prev_l              <= stable[13];
      right_arrow_pressed <= rise_r & ~rise_l;
      left_arrow_pressed  <= rise_l & ~rise_r;
    end
  end

  assign db_botoes_estaveis = notas;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Vector table plus scoreboard bench for condicionador_botoes.
// D=4: a clean change shows on registered outputs at edge 7.
module tb_condicionador_botoes;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] botoes;
  logic        right_arrow;
  logic        left_arrow;
  logic [3:0]  botoes_encoded;
  logic        right_arrow_pressed;
  logic        left_arrow_pressed;
  logic        nota_pulso;
  logic        multiplos;
  logic [11:0] db_botoes_estaveis;

  condicionador_botoes #(
    .CLOCK_FREQ (1000),
    .DEBOUNCE_MS(4)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .botoes             (botoes),
    .right_arrow        (right_arrow),
    .left_arrow         (left_arrow),
    .botoes_encoded     (botoes_encoded),
    .right_arrow_pressed(right_arrow_pressed),
    .left_arrow_pressed (left_arrow_pressed),
    .nota_pulso         (nota_pulso),
    .multiplos          (multiplos),
    .db_botoes_estaveis (db_botoes_estaveis)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] b;
    logic        ra;
    logic        la;
    int          hold;
    int          code;
    int          mult;
    int          db;
    int          np;
    int          rp;
    int          lp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   np_c;
  int   rp_c;
  int   lp_c;

  function automatic vec_t mk(logic [11:0] b, logic ra, logic la,
                              int hold, int code, int mult, int db,
                              int np, int rp, int lp);
    vec_t v;
    v.b = b; v.ra = ra; v.la = la; v.hold = hold;
    v.code = code; v.mult = mult; v.db = db;
    v.np = np; v.rp = rp; v.lp = lp;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(int n);
    np_c = 0; rp_c = 0; lp_c = 0;
    repeat (n) begin
      @(posedge clock);
      #1;
      np_c += int'(nota_pulso);
      rp_c += int'(right_arrow_pressed);
      lp_c += int'(left_arrow_pressed);
      if (botoes_encoded > 4'd12) chk("enc_range", int'(botoes_encoded), 12);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    botoes      = v.b;
    right_arrow = v.ra;
    left_arrow  = v.la;
    sb.push_back(v);
    run(v.hold);
    e = sb.pop_front();
    chk($sformatf("row%0d code", idx), int'(botoes_encoded), e.code);
    chk($sformatf("row%0d mult", idx), int'(multiplos), e.mult);
    chk($sformatf("row%0d db", idx), int'(db_botoes_estaveis), e.db);
    chk($sformatf("row%0d npulse", idx), np_c, e.np);
    chk($sformatf("row%0d rpulse", idx), rp_c, e.rp);
    chk($sformatf("row%0d lpulse", idx), lp_c, e.lp);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " code"}, int'(botoes_encoded), 0);
    chk({tag, " npulse"}, int'(nota_pulso), 0);
    chk({tag, " mult"}, int'(multiplos), 0);
    chk({tag, " rpulse"}, int'(right_arrow_pressed), 0);
    chk({tag, " lpulse"}, int'(left_arrow_pressed), 0);
    chk({tag, " db"}, int'(db_botoes_estaveis), 0);
  endtask

  initial begin
    // b, ra, la, hold, code, mult, db, np, rp, lp
    tbl.push_back(mk(12'h010, 0, 0, 6, 0, 0, 'h010, 0, 0, 0));
    tbl.push_back(mk(12'h010, 0, 0, 1, 5, 0, 'h010, 1, 0, 0));
    tbl.push_back(mk(12'h010, 0, 0, 12, 5, 0, 'h010, 0, 0, 0));
    tbl.push_back(mk(12'h000, 0, 0, 6, 5, 0, 'h000, 0, 0, 0));
    tbl.push_back(mk(12'h000, 0, 0, 1, 0, 0, 'h000, 0, 0, 0));
    tbl.push_back(mk(12'h008, 0, 0, 7, 4, 0, 'h008, 1, 0, 0));
    tbl.push_back(mk(12'h009, 0, 0, 7, 4, 1, 'h009, 0, 0, 0));
    tbl.push_back(mk(12'h001, 0, 0, 6, 4, 1, 'h001, 0, 0, 0));
    tbl.push_back(mk(12'h001, 0, 0, 1, 1, 0, 'h001, 1, 0, 0));
    tbl.push_back(mk(12'h000, 0, 0, 7, 0, 0, 'h000, 0, 0, 0));
    tbl.push_back(mk(12'h000, 1, 0, 7, 0, 0, 'h000, 0, 1, 0));
    tbl.push_back(mk(12'h000, 1, 0, 13, 0, 0, 'h000, 0, 0, 0));
    tbl.push_back(mk(12'h000, 0, 0, 8, 0, 0, 'h000, 0, 0, 0));
    tbl.push_back(mk(12'h000, 1, 1, 10, 0, 0, 'h000, 0, 0, 0));
    tbl.push_back(mk(12'h000, 0, 0, 8, 0, 0, 'h000, 0, 0, 0));
    tbl.push_back(mk(12'h020, 0, 1, 7, 6, 0, 'h020, 1, 0, 1));
    tbl.push_back(mk(12'h000, 0, 0, 8, 0, 0, 'h000, 0, 0, 0));
    tbl.push_back(mk(12'h800, 0, 0, 7, 12, 0, 'h800, 1, 0, 0));
    tbl.push_back(mk(12'h000, 0, 0, 8, 0, 0, 'h000, 0, 0, 0));
    tbl.push_back(mk(12'h040, 0, 0, 3, 0, 0, 'h000, 0, 0, 0));
    tbl.push_back(mk(12'h000, 0, 0, 8, 0, 0, 'h000, 0, 0, 0));

    reset = 1'b0;
    botoes = '0;
    right_arrow = 1'b0;
    left_arrow = 1'b0;
    #2;
    chk_zero("reset");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Bounce every two cycles never reaches the debounce window.
    begin
      int np_sum;
      int db_bad;
      np_sum = 0;
      db_bad = 0;
      for (int k = 0; k < 10; k++) begin
        botoes = (k % 2 == 0) ? 12'h004 : 12'h000;
        for (int c = 0; c < 2; c++) begin
          run(1);
          np_sum += np_c;
          if (db_botoes_estaveis != 12'h000) db_bad++;
        end
      end
      botoes = '0;
      run(8);
      np_sum += np_c;
      chk("bounce npulse", np_sum, 0);
      chk("bounce db_seen", db_bad, 0);
      chk("bounce code", int'(botoes_encoded), 0);
      chk("bounce db", int'(db_botoes_estaveis), 0);
    end

    // Reset while a latched key is held, then release with key held.
    botoes = 12'h080;
    run(7);
    chk("hold7 code", int'(botoes_encoded), 8);
    chk("hold7 npulse", np_c, 1);
    run(3);
    reset = 1'b0;
    #1;
    chk_zero("midreset");
    run(3);
    chk("midreset npulse", np_c, 0);
    reset = 1'b1;
    run(6);
    chk("rel6 code", int'(botoes_encoded), 0);
    chk("rel6 npulse", np_c, 0);
    chk("rel6 db", int'(db_botoes_estaveis), 'h080);
    run(1);
    chk("rel7 code", int'(botoes_encoded), 8);
    chk("rel7 npulse", np_c, 1);
    botoes = '0;
    run(8);
    chk("rel_off code", int'(botoes_encoded), 0);

    // Reset during debounce aborts the press.
    botoes = 12'h100;
    run(4);
    reset = 1'b0;
    #1;
    chk_zero("abort");
    botoes = '0;
    run(2);
    reset = 1'b1;
    run(8);
    chk("abort code", int'(botoes_encoded), 0);
    chk("abort npulse", np_c, 0);
    chk("abort db", int'(db_botoes_estaveis), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 Parameter: CLOCK_FREQ, 50000000, clock frequency in Hz.
REQ-002 Parameter: DEBOUNCE_MS, 10, debounce window in ms.
REQ-003 Derived constant: D = CLOCK_FREQ/1000*DEBOUNCE_MS, integer division; a result of 0 SHALL be forced to 1.
REQ-004 Port: clock  input  1  single system clock; all state changes on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: botoes  input  12  raw, asynchronous, bouncing note keys; bit i is key i.
REQ-007 Port: right_arrow, left_arrow  input  1 each  raw arrow keys.
REQ-008 Port: botoes_encoded  output  4  0 = no note; 1..12 = key index+1.
REQ-009 Port: right_arrow_pressed, left_arrow_pressed  output  1 each  one-cycle press pulses.
REQ-010 Port: nota_pulso  output  1  one-cycle pulse each time botoes_encoded takes a new nonzero code.
REQ-011 Port: multiplos  output  1  high while more than one debounced note key is held.
REQ-012 Port: db_botoes_estaveis  output  12  debounced key vector, for debug.

Function
REQ-013 Each of the 14 raw inputs SHALL pass through its own 2-flop synchronizer before any other use.
REQ-014 Each input SHALL have its own debounce counter, sized ceil(log2(D+1)), and a stable bit.
- Counter clears on any cycle where the synchronized value equals the stable bit.
- Otherwise the counter increments.
- On the D-th consecutive differing edge, the stable bit toggles and the counter clears.
REQ-015 Latency: a clean change held from before edge 1 SHALL appear on the registered outputs at edge D+3, no earlier and no later.
REQ-016 A glitch shorter than D consecutive cycles SHALL cause no change in any output.
REQ-017 The encoder FSM SHALL have exactly two states, OCIOSO and ATIVO.
REQ-018 In OCIOSO with any stable note key high:
- latch the lowest-index high key into botoes_encoded;
- pulse nota_pulso;
- go to ATIVO.
REQ-019 In ATIVO, botoes_encoded SHALL hold the latched code while that key stays stable-high, regardless of other presses.
REQ-020 In ATIVO, when the latched key drops and other keys are still high:
- latch the lowest-index remaining key;
- pulse nota_pulso;
- stay in ATIVO.
REQ-021 In ATIVO, when the latched key drops and no keys are high: botoes_encoded becomes 0 and the FSM goes to OCIOSO, with no pulse.
REQ-022 botoes_encoded SHALL never take the values 13..15.
REQ-023 The latched code and nota_pulso SHALL update on the same edge.
REQ-024 multiplos SHALL be registered, equal to (popcount of stable note keys > 1), and updated on the same edge as botoes_encoded.
REQ-025 Arrow pulses SHALL be one clock wide, on the rising edge of the corresponding stable arrow bit.
REQ-026 If both stable arrow bits rise on the same edge, neither arrow pulse SHALL assert.
REQ-027 Holding an arrow SHALL NOT repeat its pulse; a new pulse needs a debounced release and a new press.
REQ-028 Arrow and note paths SHALL be independent; simultaneous events on them both take effect.
REQ-029 db_botoes_estaveis SHALL equal the stable note bits directly, one edge ahead of botoes_encoded.

Reset
REQ-030 Asserting reset (low) SHALL immediately set the following, without waiting for a clock edge:
- all synchronizers, counters and stable bits to 0;
- FSM to OCIOSO;
- every output to 0.
REQ-031 Reset asserted mid-press SHALL abort the press with no pulse.
REQ-032 After reset release, a key still held SHALL be treated as a new press and appear at edge D+3 with nota_pulso.

Verification
Bench parameters: CLOCK_FREQ=1000, DEBOUNCE_MS=4, so D=4 and latency is 7 edges.
REQ-033 Hold botoes[4] -> at edge 7: botoes_encoded=5 and nota_pulso=1 for exactly one cycle; botoes_encoded stays 5 while held; 0 at the 7th edge after release, with no pulse.
REQ-034 Toggle botoes[2] every 2 cycles for 20 cycles, then hold low -> botoes_encoded stays 0, no nota_pulso, db_botoes_estaveis stays 0.
REQ-035 Hold key 3, then add key 0 -> botoes_encoded stays 4 and multiplos=1; release key 3 -> botoes_encoded=1 with one nota_pulso; multiplos=0.
REQ-036 Arrows:
- right_arrow held 20 cycles -> single right_arrow_pressed pulse at edge 7, no repeat;
- both arrows raised together -> no pulse on either output.
REQ-037 Hold key 7, assert reset mid-hold -> all outputs 0 asynchronously; release reset with key held -> botoes_encoded=8 and nota_pulso at edge 7 after release.
